data_memory: RTL and testbench

- Data-side memory of the pipelined CPU, 24-bit words, 19-bit word address.
- Two address ports: port 1 is read/write (load/store path), port 2 is read-only (second read path).
- Memory-mapped I/O:
  - 4 board switches, read-only.
  - 36 GPIO pins: input bus readable, output bus writable.
- Sits between the MEM stage and the board I/O.

---
 rtl/data_memory_pkg.sv | 42 ++++
 rtl/data_memory_dp_ram.sv | 35 +++
 rtl/data_memory.sv | 130 +++++++++++++
 tb/tb_data_memory.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// Shared widths, I/O map constants and the address-to-region decoder
// used by both ports of the data memory.
package data_memory_pkg;

   localparam int ADDR_W        = 19;
   localparam int DATA_W        = 24;
   localparam int GPIO_W        = 36;
   localparam int SW_W          = 4;
   localparam int GPIO_BASE_DEF = 36;
   localparam int SW_BASE_DEF   = 75;
   localparam int RSV_FIRST     = GPIO_BASE_DEF + GPIO_W;
   localparam int RSV_LAST      = SW_BASE_DEF - 1;

   typedef enum logic [1:0] {
      REG_RAM,
      REG_GPIO,
      REG_SW,
      REG_NONE
   } region_t;

   // The gap between the GPIO block and the switch block is reserved.
   function automatic region_t decode_region(
      input logic [ADDR_W-1:0] addr,
      input int                gpio_base,
      input int                sw_base,
      input int                ram_depth
   );
      int a;
      a = int'(addr);
      if (a >= gpio_base && a < gpio_base + GPIO_W)
         return REG_GPIO;
      else if (a >= gpio_base + GPIO_W && a < sw_base)
         return REG_NONE;
      else if (a >= sw_base && a < sw_base + SW_W)
         return REG_SW;
      else if (a < ram_depth)
         return REG_RAM;
      else
         return REG_NONE;
   endfunction

endpackage

// File: rtl/data_memory_dp_ram.sv
// Simple dual-port RAM: port A read/write (write-first), port B read-only
// (returns the old word on a same-address collision). Registered reads.
module dp_ram #(
   parameter int DEPTH = 65536,
   parameter int AW    = 16,
   parameter int DW    = 24
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr_a,
   input  logic [DW-1:0] din_a,
   input  logic [AW-1:0] addr_b,
   output logic [DW-1:0] dout_a,
   output logic [DW-1:0] dout_b
);

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] dout_a_reg;
   logic [DW-1:0] dout_b_reg;

   // No reset on the read registers so the whole block maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr_a] <= din_a;
         dout_a_reg  <= din_a;
      end else begin
         dout_a_reg  <= mem[addr_a];
      end
      dout_b_reg <= mem[addr_b];
   end

   assign dout_a = dout_a_reg;
   assign dout_b = dout_b_reg;

endmodule

// File: rtl/data_memory.sv
// CPU data memory: RAM plus memory-mapped switches and GPIO on two ports.
// Read data is selected by the region registered alongside the RAM read.
module data_memory
   import data_memory_pkg::*;
#(
   parameter int RAM_DEPTH = 65536,
   parameter int GPIO_BASE = GPIO_BASE_DEF,
   parameter int SW_BASE   = SW_BASE_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memWrite,
   input  logic [ADDR_W-1:0] address1,
   input  logic [ADDR_W-1:0] address2,
   input  logic [DATA_W-1:0] data1,
   input  logic [DATA_W-1:0] data2,
   input  logic [SW_W-1:0]   switches,
   input  logic [GPIO_W-1:0] gpio1,
   output logic [GPIO_W-1:0] gpio2,
   output logic [DATA_W-1:0] qa,
   output logic [DATA_W-1:0] qb
);

   localparam int RAM_AW = $clog2(RAM_DEPTH);

   region_t           region_a, region_b;
   region_t           region_a_reg, region_b_reg;
   logic              io_bit_a, io_bit_b;
   logic              io_bit_a_reg, io_bit_b_reg;
   logic [GPIO_W-1:0] gpio_hit_a, gpio_hit_b;
   logic [SW_W-1:0]   sw_hit_a, sw_hit_b;
   logic [GPIO_W-1:0] gpio2_reg;
   logic [DATA_W-1:0] ram_qa, ram_qb;
   logic              ram_we;
   logic              gpio_wr;
   logic              unused_data2;

   assign unused_data2 = ^data2;

   assign region_a = decode_region(address1, GPIO_BASE, SW_BASE, RAM_DEPTH);
   assign region_b = decode_region(address2, GPIO_BASE, SW_BASE, RAM_DEPTH);

   // One-hot hit vectors pick the addressed pin without a subtract-and-index.
   generate
      for (genvar gi = 0; gi < GPIO_W; gi++) begin : g_gpio_hit
         assign gpio_hit_a[gi] = (address1 == ADDR_W'(GPIO_BASE + gi));
         assign gpio_hit_b[gi] = (address2 == ADDR_W'(GPIO_BASE + gi));
      end
      for (genvar gi = 0; gi < SW_W; gi++) begin : g_sw_hit
         assign sw_hit_a[gi] = (address1 == ADDR_W'(SW_BASE + gi));
         assign sw_hit_b[gi] = (address2 == ADDR_W'(SW_BASE + gi));
      end
   endgenerate

   always_comb begin
      io_bit_a = 1'b0;
      io_bit_b = 1'b0;
      case (region_a)
         REG_GPIO: io_bit_a = |(gpio1 & gpio_hit_a);
         REG_SW:   io_bit_a = |(switches & sw_hit_a);
         default:  io_bit_a = 1'b0;
      endcase
      case (region_b)
         REG_GPIO: io_bit_b = |(gpio1 & gpio_hit_b);
         REG_SW:   io_bit_b = |(switches & sw_hit_b);
         default:  io_bit_b = 1'b0;
      endcase
   end

   assign ram_we  = rst && memWrite && (region_a == REG_RAM);
   assign gpio_wr = memWrite && (region_a == REG_GPIO);

   dp_ram #(
      .DEPTH (RAM_DEPTH),
      .AW    (RAM_AW),
      .DW    (DATA_W)
   ) u_ram (
      .clk    (clk),
      .we     (ram_we),
      .addr_a (address1[RAM_AW-1:0]),
      .din_a  (data1),
      .addr_b (address2[RAM_AW-1:0]),
      .dout_a (ram_qa),
      .dout_b (ram_qb)
   );

   // Resetting the region to REG_NONE is what forces qa/qb to zero.
   always_ff @(posedge clk) begin
      if (!rst) begin
         region_a_reg <= REG_NONE;
         region_b_reg <= REG_NONE;
         io_bit_a_reg <= 1'b0;
         io_bit_b_reg <= 1'b0;
      end else begin
         region_a_reg <= region_a;
         region_b_reg <= region_b;
         io_bit_a_reg <= io_bit_a;
         io_bit_b_reg <= io_bit_b;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         gpio2_reg <= '0;
      end else begin
         for (int i = 0; i < GPIO_W; i++) begin
            if (gpio_wr && gpio_hit_a[i])
               gpio2_reg[i] <= data1[0];
         end
      end
   end

   always_comb begin
      qa = '0;
      qb = '0;
      case (region_a_reg)
         REG_RAM:         qa = ram_qa;
         REG_GPIO, REG_SW: qa = {{(DATA_W-1){1'b0}}, io_bit_a_reg};
         default:         qa = '0;
      endcase
      case (region_b_reg)
         REG_RAM:         qb = ram_qb;
         REG_GPIO, REG_SW: qb = {{(DATA_W-1){1'b0}}, io_bit_b_reg};
         default:         qb = '0;
      endcase
   end

   assign gpio2 = gpio2_reg;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: expected read data is queued when a
// transaction is driven and compared after the edge that produces it.
module tb_data_memory;

   logic        clk = 1'b0;
   logic        rst;
   logic        memWrite;
   logic [18:0] address1, address2;
   logic [23:0] data1, data2;
   logic [3:0]  switches;
   logic [35:0] gpio1;
   logic [35:0] gpio2;
   logic [23:0] qa, qb;

   typedef struct {
      logic [23:0] qa;
      logic [23:0] qb;
      bit          chk_b;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   tests_run    = 0;
   int   tests_failed = 0;

   always #5 clk = ~clk;

   data_memory dut (
      .clk      (clk),
      .rst      (rst),
      .memWrite (memWrite),
      .address1 (address1),
      .address2 (address2),
      .data1    (data1),
      .data2    (data2),
      .switches (switches),
      .gpio1    (gpio1),
      .gpio2    (gpio2),
      .qa       (qa),
      .qb       (qb)
   );

   task automatic drive(input logic we, input int a1, input int a2, input logic [23:0] d1);
      memWrite = we;
      address1 = 19'(a1);
      address2 = 19'(a2);
      data1    = d1;
      data2    = 24'hA5A5A5;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 100, 100, 24'd5);
         sb.push_back('{qa: 24'd0, qb: 24'd0, chk_b: 1'b1});
         tick();
         e = sb.pop_front();
         tests_run++;
         if (qa !== e.qa || qb !== e.qb) begin
            tests_failed++;
            $display("FAIL reset_q cyc%0d: qa=%h qb=%h expected %h/%h", i, qa, qb, e.qa, e.qb);
         end
         tests_run++;
         if (gpio2 !== 36'h0) begin
            tests_failed++;
            $display("FAIL reset_gpio2 cyc%0d: got %h expected 0", i, gpio2);
         end
      end
      $display("[TB] reset: held 2 cycles with write to 100");
   endtask

   task automatic test_reset_write();
      rst = 1'b1;
      drive(1'b1, 100, 0, 24'd7);
      sb.push_back('{qa: 24'd7, qb: 24'd0, chk_b: 1'b0});
      tick();
      e = sb.pop_front();
      tests_run++;
      if (qa !== e.qa) begin
         tests_failed++;
         $display("FAIL rw_preload qa: got %h expected %h", qa, e.qa);
      end
      rst = 1'b0;
      drive(1'b1, 100, 100, 24'd5);
      sb.push_back('{qa: 24'd0, qb: 24'd0, chk_b: 1'b1});
      tick();
      e = sb.pop_front();
      tests_run++;
      if (qa !== e.qa || qb !== e.qb) begin
         tests_failed++;
         $display("FAIL rw_in_reset: qa=%h qb=%h expected %h/%h", qa, qb, e.qa, e.qb);
      end
      rst = 1'b1;
      drive(1'b0, 100, 100, 24'd9);
      sb.push_back('{qa: 24'd7, qb: 24'd7, chk_b: 1'b1});
      tick();
      e = sb.pop_front();
      tests_run++;
      if (qa !== e.qa || qb !== e.qb) begin
         tests_failed++;
         $display("FAIL rw_after_reset: qa=%h qb=%h expected %h/%h", qa, qb, e.qa, e.qb);
      end
      $display("[TB] reset_write: addr 100 keeps 7 across reset write of 5");
   endtask

   task automatic test_switches();
      int          a1 [5] = '{75, 76, 77, 78, 74};
      int          a2 [5] = '{78, 77, 76, 75, 73};
      logic [23:0] ea [5] = '{24'd0, 24'd1, 24'd0, 24'd1, 24'd0};
      logic [23:0] eb [5] = '{24'd1, 24'd0, 24'd1, 24'd0, 24'd0};
      switches = 4'b1010;
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, a1[i], a2[i], 24'h0);
         sb.push_back('{qa: ea[i], qb: eb[i], chk_b: 1'b1});
         tick();
         e = sb.pop_front();
         tests_run++;
         if (qa !== e.qa || qb !== e.qb) begin
            tests_failed++;
            $display("FAIL switches a1=%0d a2=%0d: qa=%h qb=%h expected %h/%h",
                     a1[i], a2[i], qa, qb, e.qa, e.qb);
         end
      end
      $display("[TB] switches: 4'b1010 read on both ports");
   endtask

   task automatic test_ram();
      drive(1'b1, 50000, 0, 24'h123456);
      sb.push_back('{qa: 24'h123456, qb: 24'h0, chk_b: 1'b0});
      tick();
      e = sb.pop_front();
      tests_run++;
      if (qa !== e.qa) begin
         tests_failed++;
         $display("FAIL ram_preload qa: got %h expected %h", qa, e.qa);
      end
      drive(1'b1, 50000, 50000, 24'd255);
      sb.push_back('{qa: 24'd255, qb: 24'h123456, chk_b: 1'b1});
      tick();
      e = sb.pop_front();
      tests_run++;
      if (qa !== e.qa || qb !== e.qb) begin
         tests_failed++;
         $display("FAIL ram_collision: qa=%h qb=%h expected %h/%h", qa, qb, e.qa, e.qb);
      end
      drive(1'b0, 50000, 50000, 24'd27);
      sb.push_back('{qa: 24'd255, qb: 24'd255, chk_b: 1'b1});
      tick();
      e = sb.pop_front();
      tests_run++;
      if (qa !== e.qa || qb !== e.qb) begin
         tests_failed++;
         $display("FAIL ram_we_low: qa=%h qb=%h expected %h/%h", qa, qb, e.qa, e.qb);
      end
      $display("[TB] ram: 50000 write-first, old data on port 2, we=0 holds");
   endtask

   task automatic test_gpio_out();
      int          a  [4] = '{38, 71, 38, 71};
      logic [23:0] d  [4] = '{24'd1, 24'hFFFFF3, 24'hFFFFFE, 24'd0};
      logic [35:0] eg [4] = '{36'h4, 36'h8_0000_0004, 36'h8_0000_0000, 36'h0};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, a[i], 0, d[i]);
         tick();
         tests_run++;
         if (gpio2 !== eg[i]) begin
            tests_failed++;
            $display("FAIL gpio_out addr=%0d data=%h: got %h expected %h", a[i], d[i], gpio2, eg[i]);
         end
      end
      $display("[TB] gpio_out: bits 2 and 35 set and cleared");
   endtask

   task automatic test_gpio_in_unmapped();
      int          a1 [4] = '{38, 39, 73, 70000};
      int          a2 [4] = '{71, 36, 72, 524287};
      logic [23:0] ea [4] = '{24'd1, 24'd0, 24'd0, 24'd0};
      logic [23:0] eb [4] = '{24'd1, 24'd0, 24'd0, 24'd0};
      gpio1 = 36'h8_0000_0004;
      // 70000 aliases RAM word 4464 if the upper address bits were ignored.
      drive(1'b1, 4464, 0, 24'hABCDEF);
      tick();
      drive(1'b1, 38, 0, 24'd1);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, a1[i], a2[i], 24'h0);
         sb.push_back('{qa: ea[i], qb: eb[i], chk_b: 1'b1});
         tick();
         e = sb.pop_front();
         tests_run++;
         if (qa !== e.qa || qb !== e.qb) begin
            tests_failed++;
            $display("FAIL gpio_in a1=%0d a2=%0d: qa=%h qb=%h expected %h/%h",
                     a1[i], a2[i], qa, qb, e.qa, e.qb);
         end
      end
      drive(1'b1, 73, 0, 24'h000110);
      sb.push_back('{qa: 24'd0, qb: 24'd0, chk_b: 1'b0});
      tick();
      e = sb.pop_front();
      tests_run++;
      if (qa !== e.qa || gpio2 !== 36'h4) begin
         tests_failed++;
         $display("FAIL wr_reserved: qa=%h gpio2=%h expected %h/%h", qa, gpio2, e.qa, 36'h4);
      end
      drive(1'b1, 70000, 0, 24'h000111);
      sb.push_back('{qa: 24'd0, qb: 24'd0, chk_b: 1'b0});
      tick();
      e = sb.pop_front();
      tests_run++;
      if (qa !== e.qa || gpio2 !== 36'h4) begin
         tests_failed++;
         $display("FAIL wr_unmapped: qa=%h gpio2=%h expected %h/%h", qa, gpio2, e.qa, 36'h4);
      end
      drive(1'b0, 4464, 50000, 24'h0);
      sb.push_back('{qa: 24'hABCDEF, qb: 24'd255, chk_b: 1'b1});
      tick();
      e = sb.pop_front();
      tests_run++;
      if (qa !== e.qa || qb !== e.qb) begin
         tests_failed++;
         $display("FAIL ram_untouched: qa=%h qb=%h expected %h/%h", qa, qb, e.qa, e.qb);
      end
      $display("[TB] gpio_in/unmapped: pin reads, ignored writes");
   endtask

   task automatic test_back_to_back();
      logic [23:0] d [8];
      for (int i = 0; i < 8; i++) begin
         d[i] = 24'($urandom_range(0, 24'hFFFFFF));
         drive(1'b1, 1000 + i, (i == 0) ? 1000 : 999 + i, d[i]);
         sb.push_back('{qa: d[i], qb: (i == 0) ? 24'h0 : d[i-1], chk_b: (i != 0)});
         tick();
         e = sb.pop_front();
         tests_run++;
         if (qa !== e.qa || (e.chk_b && qb !== e.qb)) begin
            tests_failed++;
            $display("FAIL b2b_write i=%0d: qa=%h qb=%h expected %h/%h", i, qa, qb, e.qa, e.qb);
         end
      end
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1000 + i, 1007 - i, 24'h0);
         sb.push_back('{qa: d[i], qb: d[7-i], chk_b: 1'b1});
         tick();
         e = sb.pop_front();
         tests_run++;
         if (qa !== e.qa || qb !== e.qb) begin
            tests_failed++;
            $display("FAIL b2b_read i=%0d: qa=%h qb=%h expected %h/%h", i, qa, qb, e.qa, e.qb);
         end
      end
      $display("[TB] back_to_back: 8 writes then 8 crossed reads");
   endtask

   initial begin
      rst      = 1'b0;
      switches = 4'h0;
      gpio1    = 36'h0;
      drive(1'b0, 0, 0, 24'h0);
      #1;
      test_reset();
      test_reset_write();
      test_switches();
      test_ram();
      test_gpio_out();
      test_gpio_in_unmapped();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
